// File: rtl/fetch_pkg.sv
// Shared opcode constants and immediate decoders for the fetch stage.
package fetch_pkg;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // J-type offset, sign-extended to 32 bits (bit 0 always zero).
   function automatic logic [31:0] imm_j(input logic [31:0] inst);
      return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

   // B-type offset, sign-extended to 32 bits (bit 0 always zero).
   function automatic logic [31:0] imm_b(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, inst, pred} entries; head is read straight from storage.
// Caller must not push when full or pop when empty; flush empties the queue in one cycle.
module fetch_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic            flush,
   input  logic [XLEN-1:0] push_pc,
   input  logic [XLEN-1:0] push_inst,
   input  logic            push_pred,
   output logic            full,
   output logic            empty,
   output logic [XLEN-1:0] head_pc,
   output logic [XLEN-1:0] head_inst,
   output logic            head_pred
);

   localparam int AW = $clog2(DEPTH);

   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [XLEN-1:0] inst_mem [DEPTH];
   logic            pred_mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            inst_mem[i] <= '0;
            pred_mem[i] <= 1'b0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
            pred_mem[wr_ptr] <= push_pred;
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign full      = (count == (AW+1)'(DEPTH));
   assign empty     = (count == '0);
   assign head_pc   = pc_mem[rd_ptr];
   assign head_inst = inst_mem[rd_ptr];
   assign head_pred = pred_mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: PC sequencing, control-flow stall/redirect, and a decoupling queue to decode.
// Define FETCH_STATIC_PREDICT_EN to follow JAL and backward branches instead of stalling.
module inst_fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            rdy_in,
   output logic            need_inst,
   output logic [XLEN-1:0] PC,
   input  logic            inst_ready_in,
   input  logic [XLEN-1:0] inst_in,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_addr,
   output logic [XLEN-1:0] inst_out,
   output logic            inst_pred_taken,
   input  logic            dc_clear,
   input  logic [XLEN-1:0] dc_new_pc,
   input  logic            rob_clear,
   input  logic [XLEN-1:0] rob_new_pc
);

   import fetch_pkg::*;

   logic            stall;
   logic            full;
   logic            empty;
   logic            dc_redirect;
   logic            push;
   logic            pop;
   logic            flush;
   logic [XLEN-1:0] next_pc;
   logic            push_pred;
   logic            push_stall;

   // Decoder handshake: head transfers when inst_valid && inst_ready on a clock edge;
   // inst_valid never drops without a transfer except on rob_clear or reset.
   assign need_inst   = !stall && !full;
   assign inst_valid  = !empty;
   assign dc_redirect = stall && dc_clear;
   assign push  = rdy_in && inst_ready_in && need_inst && !rob_clear && !dc_redirect;
   assign pop   = rdy_in && inst_valid && inst_ready && !rob_clear;
   assign flush = rdy_in && rob_clear;

   always_comb begin
      next_pc    = PC + XLEN'(4);
      push_pred  = 1'b0;
      push_stall = 1'b0;
`ifdef FETCH_STATIC_PREDICT_EN
      case (inst_in[6:0])
         OPC_JAL: begin
            next_pc   = PC + XLEN'($signed(imm_j(inst_in[31:0])));
            push_pred = 1'b1;
         end
         OPC_BRANCH: begin
            // Backward branches are predicted taken (loop heuristic).
            if (inst_in[31]) begin
               next_pc   = PC + XLEN'($signed(imm_b(inst_in[31:0])));
               push_pred = 1'b1;
            end
         end
         OPC_JALR: push_stall = 1'b1;
         default:  push_stall = 1'b0;
      endcase
`else
      if (inst_in[6:0] == OPC_JAL || inst_in[6:0] == OPC_JALR ||
          inst_in[6:0] == OPC_BRANCH)
         push_stall = 1'b1;
`endif
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         PC    <= RESET_PC;
         stall <= 1'b0;
      end else if (rdy_in) begin
         if (rob_clear) begin
            PC    <= rob_new_pc;
            stall <= 1'b0;
         end else if (dc_redirect) begin
            PC    <= dc_new_pc;
            stall <= 1'b0;
         end else if (push) begin
            PC    <= next_pc;
            stall <= push_stall;
         end
      end
   end

   fetch_queue #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk       (clk_in),
      .rst       (rst_in),
      .push      (push),
      .pop       (pop),
      .flush     (flush),
      .push_pc   (PC),
      .push_inst (inst_in),
      .push_pred (push_pred),
      .full      (full),
      .empty     (empty),
      .head_pc   (inst_addr),
      .head_inst (inst_out),
      .head_pred (inst_pred_taken)
   );

endmodule
